// File: rtl/rgb_btn_selector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_btn_selector: debounces three active-low buttons and toggles the       |
// | matching RGB colour-select bit once per qualified press.                   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module rgb_btn_selector #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [2:0] btn_n,
  output logic [2:0] led_sel,
  output logic [2:0] btn_lvl,
  output logic       sel_valid
);

  localparam int              C_CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_UP       = 2'd0,
    ST_DOWN_CHK = 2'd1,
    ST_DOWN     = 2'd2,
    ST_UP_CHK   = 2'd3
  } state_t;

  logic [2:0] sync1_q;
  logic [2:0] sync2_q;
  logic [2:0] w_tog;
  logic       sel_valid_q;

  // Flops reset to 1 so a held button looks released right after reset.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_btn
    state_t             state_q;
    logic [C_CNT_W-1:0] cnt_q;
    logic               led_q;
    logic               lvl_q;
    logic               tog_q;
    logic               w_pressed;

    assign w_pressed = ~sync2_q[gi];

    always_ff @(posedge clk_in) begin
      if (!reset) begin
        state_q <= ST_UP;
        cnt_q   <= '0;
        led_q   <= 1'b0;
        lvl_q   <= 1'b0;
        tog_q   <= 1'b0;
      end else begin
        tog_q <= 1'b0;
        case (state_q)
          ST_UP: begin
            if (w_pressed) begin
              state_q <= ST_DOWN_CHK;
              cnt_q   <= '0;
            end
          end
          ST_DOWN_CHK: begin
            if (!w_pressed) begin
              state_q <= ST_UP;
            end else if (cnt_q == C_CNT_MAX) begin
              state_q <= ST_DOWN;
              lvl_q   <= 1'b1;
              led_q   <= ~led_q;
              tog_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          ST_DOWN: begin
            if (!w_pressed) begin
              state_q <= ST_UP_CHK;
              cnt_q   <= '0;
            end
          end
          ST_UP_CHK: begin
            if (w_pressed) begin
              state_q <= ST_DOWN;
            end else if (cnt_q == C_CNT_MAX) begin
              state_q <= ST_UP;
              lvl_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_UP;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
          end
        endcase
      end
    end

    assign led_sel[gi] = led_q;
    assign btn_lvl[gi] = lvl_q;
    assign w_tog[gi]   = tog_q;
  end

  // Toggles land together, so one pulse covers any number of simultaneous presses.
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      sel_valid_q <= 1'b0;
    end else begin
      sel_valid_q <= |w_tog;
    end
  end

  assign sel_valid = sel_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_btn_selector.sv
`default_nettype none
// Testbench for rgb_btn_selector: directed scenarios plus randomized button
// activity, checked every cycle against a run-length debounce model.
module tb_rgb_btn_selector;

  localparam int D = 4;

  logic       clk_in = 1'b0;
  logic       reset  = 1'b0;
  logic [2:0] btn_n  = 3'b111;
  logic [2:0] led_sel;
  logic [2:0] btn_lvl;
  logic       sel_valid;

  int n_chk  = 0;
  int n_fail = 0;
  int sel_cnt = 0;

  // Model state: sampled input pipeline, accepted level, mismatch run length.
  logic [2:0] m_s1 = 3'b111;
  logic [2:0] m_s2 = 3'b111;
  logic [2:0] m_lvl = 3'b000;
  logic [2:0] m_led = 3'b000;
  logic [2:0] m_tog = 3'b000;
  logic       m_sel = 1'b0;
  int         m_run [3] = '{0, 0, 0};

  rgb_btn_selector #(.DEBOUNCE_CYCLES(D)) dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .btn_n     (btn_n),
    .led_sel   (led_sel),
    .btn_lvl   (btn_lvl),
    .sel_valid (sel_valid)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0b%b) expected %0d (0b%b) at %0t", nm, act, act[2:0], exp, exp[2:0], $time);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic [2:0] b;
    logic       r;
    logic [2:0] nt;
    logic       ns;
    logic       p;
    b = btn_n;
    r = reset;
    @(posedge clk_in);
    if (!r) begin
      m_s1 = 3'b111; m_s2 = 3'b111; m_lvl = 3'b000; m_led = 3'b000;
      m_tog = 3'b000; m_sel = 1'b0;
      for (int i = 0; i < 3; i++) m_run[i] = 0;
    end else begin
      ns = |m_tog;
      nt = 3'b000;
      for (int i = 0; i < 3; i++) begin
        p = !m_s2[i];
        if (p != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == D + 1) begin
            m_lvl[i] = p;
            m_run[i] = 0;
            if (p) begin
              m_led[i] = ~m_led[i];
              nt[i] = 1'b1;
            end
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2  = m_s1;
      m_s1  = b;
      m_tog = nt;
      m_sel = ns;
    end
    #1;
    chk("led_sel", int'(led_sel), int'(m_led));
    chk("btn_lvl", int'(btn_lvl), int'(m_lvl));
    chk("sel_valid", int'(sel_valid), int'(m_sel));
    if (sel_valid) sel_cnt++;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int hold [3];
    logic [2:0] b;

    // Reset state
    reset = 1'b0; btn_n = 3'b111;
    steps(3);
    chk("reset_led", int'(led_sel), 0);
    chk("reset_lvl", int'(btn_lvl), 0);
    chk("reset_sel", int'(sel_valid), 0);
    reset = 1'b1;

    // Idle: nothing pressed
    sel_cnt = 0;
    steps(20);
    chk("idle_led", int'(led_sel), 0);
    chk("idle_sel_pulses", sel_cnt, 0);

    // Single press on red, latency and one-shot pulse
    btn_n = 3'b110;
    steps(6);
    chk("press_led_before", int'(led_sel), 0);
    step();
    chk("press_led_at_latency", int'(led_sel), 1);
    chk("press_lvl", int'(btn_lvl), 1);
    step();
    chk("press_sel_pulse", int'(sel_valid), 1);
    step();
    chk("press_sel_end", int'(sel_valid), 0);
    sel_cnt = 0;
    steps(50);
    chk("hold_led", int'(led_sel), 1);
    chk("hold_no_repeat", sel_cnt, 0);

    // Bounce on green while red stays held
    sel_cnt = 0;
    btn_n = 3'b100; steps(3);
    btn_n = 3'b110; steps(1);
    btn_n = 3'b100; steps(2);
    btn_n = 3'b110; steps(10);
    chk("bounce_led", int'(led_sel), 1);
    chk("bounce_sel_pulses", sel_cnt, 0);

    // Release red
    btn_n = 3'b111;
    steps(10);
    chk("release_lvl", int'(btn_lvl), 0);
    chk("release_led", int'(led_sel), 1);

    // All three at once
    sel_cnt = 0;
    btn_n = 3'b000;
    steps(12);
    chk("all_led", int'(led_sel), 6);
    chk("all_sel_pulses", sel_cnt, 1);
    btn_n = 3'b111;
    steps(10);

    // Reset mid-debounce on blue, held through release
    btn_n = 3'b011;
    steps(3);
    reset = 1'b0;
    step();
    chk("midreset_led", int'(led_sel), 0);
    reset = 1'b1;
    steps(6);
    chk("requal_led_before", int'(led_sel), 0);
    step();
    chk("requal_led", int'(led_sel), 4);
    btn_n = 3'b111;
    steps(10);

    // Randomized per-bit hold times with occasional reset
    for (int i = 0; i < 3; i++) hold[i] = 0;
    b = 3'b111;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (hold[i] == 0) begin
          b[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 10);
        end else begin
          hold[i]--;
        end
      end
      btn_n = b;
      reset = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
